// File: rtl/cache_pkg.sv
// Shared request definitions for the cache channel issue path: op encodings,
// the request record carried through the issue FIFO, and the bank-select field.
package cache_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;
  localparam logic [1:0] OP_INV   = 2'd3;

  localparam int BANK_HI = 9;
  localparam int BANK_LO = 8;

  typedef struct packed {
    logic [1:0]   op;
    logic [31:4]  addr;
    logic [127:0] data;
  } chn_req_t;

  function automatic logic [1:0] bank_of(input logic [31:4] addr);
    return addr[BANK_HI:BANK_LO];
  endfunction

endpackage

// File: rtl/isu_chn_issue_if.sv
// Client request port and xbar request channel of one issue stage, plus the
// xbar's credit-return bits for that channel.
interface isu_chn_issue_if;
  // valid/ready: a transfer happens on every clk edge where valid (up_valid /
  // mpc_channel_valid) and ready (up_ready / mpc_channel_enable) are both 1;
  // the sender keeps valid and payload stable until that edge.
  logic         up_valid;
  logic         up_ready;
  logic [1:0]   up_op;
  logic [27:0]  up_addr;
  logic [127:0] up_data;
  logic         mpc_channel_valid;
  logic         mpc_channel_enable;
  logic [1:0]   mpc_channel_op;
  logic [27:0]  mpc_channel_address;
  logic [127:0] mpc_channel_data;
  logic [3:0]   crdt_rtn_bank;

  modport slave (
    input  up_valid, up_op, up_addr, up_data, mpc_channel_enable, crdt_rtn_bank,
    output up_ready, mpc_channel_valid, mpc_channel_op, mpc_channel_address,
           mpc_channel_data
  );

  modport master (
    output up_valid, up_op, up_addr, up_data, mpc_channel_enable, crdt_rtn_bank,
    input  up_ready, mpc_channel_valid, mpc_channel_op, mpc_channel_address,
           mpc_channel_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock in-order FIFO; the head entry is read combinationally from storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/isu_chn_issue.sv
// Per-channel issue stage: buffers client requests in order and holds back any
// read whose bank has no return credit left, so the xbar return buffer cannot overflow.
module isu_chn_issue
  import cache_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  localparam int CNT_W  = $clog2(CREDITS + 1),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  isu_chn_issue_if.slave        bus,
  output logic [3:0]            crdt_avail,
  output logic [CW-1:0]         fifo_count,
  output logic                  crdt_err,
  output logic [3:0][CNT_W-1:0] crdt_cnt
);

  chn_req_t   req_in;
  chn_req_t   head;
  logic       full;
  logic       empty;
  logic       issue;
  logic       head_needs_crdt;
  logic [1:0] head_bank;
  logic [3:0] consume;

  assign req_in.op   = bus.up_op;
  assign req_in.addr = bus.up_addr;
  assign req_in.data = bus.up_data;

  sync_fifo #(
    .WIDTH ($bits(chn_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (bus.up_valid && bus.up_ready),
    .push_data (req_in),
    .pop       (issue),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign bus.up_ready = !full;

  assign head_bank       = bank_of(head.addr);
  assign head_needs_crdt = !empty && (head.op == OP_READ);

  // Valid depends only on registers, so it cannot drop before the handshake.
  assign bus.mpc_channel_valid   = !empty && (!head_needs_crdt || (crdt_cnt[head_bank] != '0));
  assign bus.mpc_channel_op      = head.op;
  assign bus.mpc_channel_address = head.addr;
  assign bus.mpc_channel_data    = head.data;

  assign issue = bus.mpc_channel_valid && bus.mpc_channel_enable;

  always_comb begin
    consume = '0;
    if (issue && head_needs_crdt) consume[head_bank] = 1'b1;
  end

  always_comb begin
    crdt_avail = '0;
    for (int b = 0; b < 4; b++) crdt_avail[b] = (crdt_cnt[b] != '0);
  end

  // A same-bank return and consume cancel; a return at full count saturates and flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int b = 0; b < 4; b++) crdt_cnt[b] <= CNT_W'(CREDITS);
      crdt_err <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.crdt_rtn_bank[b] && !consume[b]) begin
          if (crdt_cnt[b] == CNT_W'(CREDITS)) crdt_err    <= 1'b1;
          else                                crdt_cnt[b] <= crdt_cnt[b] + 1'b1;
        end else if (consume[b] && !bus.crdt_rtn_bank[b]) begin
          crdt_cnt[b] <= crdt_cnt[b] - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/isu_chn_issue.md
Name: isu_chn_issue

Overview:
- Per-channel issue stage that sits directly upstream of one xbar request channel (channel 0, 1 or 2); one instance per channel.
- Buffers requests from the master-port client in an in-order FIFO.
- Gates each read on a per-bank return credit, so the xbar's stream write buffer for this channel can never overflow. This is what lets the xbar tie its return-path ready high.
- Consumes the xbar's credit-return bits for this channel.

Parameters:
- DEPTH, 4: request FIFO entries; power of two, minimum 2.
- CREDITS, 4: initial and maximum read credits per bank for this channel.
- CNT_W, $clog2(CREDITS+1): localparam, width of each credit counter.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- up_valid  in  1  client request valid
- up_ready  out  1  request FIFO can accept
- up_op  in  2  0=read, 1=write, 2=flush, 3=invalidate
- up_addr  in  28  address [31:4]; bank = addr[9:8]
- up_data  in  128  write data
- mpc_channel_valid  out  1  request to xbar channel
- mpc_channel_enable  in  1  xbar accepts
- mpc_channel_op  out  2  head-entry op
- mpc_channel_address  out  28  head-entry address [31:4]
- mpc_channel_data  out  128  head-entry data
- crdt_rtn_bank  in  4  bit b = one credit returned for bank b (this channel's bit of the xbar credit-return vector)
- crdt_avail  out  4  bit b = bank b credit counter nonzero
- fifo_count  out  $clog2(DEPTH+1)  occupied entries
- crdt_err  out  1  sticky: credit returned while the counter was already at CREDITS

Behaviour:
- Reset (rstn low at a clk edge), required values after that edge:
  - FIFO pointers 0; fifo_count 0; up_ready 1; mpc_channel_valid 0.
  - All four credit counters = CREDITS; crdt_avail 4'b1111; crdt_err 0.
  - FIFO payload is not reset; mpc_channel_op/address/data are don't-care while valid is 0.
- Reset mid-operation: in-flight FIFO entries are discarded and credits are restored to CREDITS.
- Push: up_valid & up_ready at an edge writes the entry.
- up_ready = (fifo_count != DEPTH). It is not fed through from a same-cycle pop.
- Head entry drives the mpc_channel_op/address/data outputs combinationally from storage.
- Minimum latency is 1 cycle: a push at edge N gives mpc_channel_valid high in cycle N+1 (given credit).
- head_needs_crdt = fifo nonempty & head op == 0.
- mpc_channel_valid = nonempty & (!head_needs_crdt | crdt_cnt[head bank] != 0).
- Issue handshake = mpc_channel_valid & mpc_channel_enable. It pops the head.
- If the popped head is a read, it decrements crdt_cnt[head bank] by 1.
- Stability rule: once mpc_channel_valid is asserted it stays high, with op/address/data unchanged, until the handshake.
  - This holds by construction: credits only decrease on a handshake, and the head only changes on a pop.
  - The bench asserts this rule.
- Strictly in order: a read with no credit blocks every younger entry, including writes and writes to other banks (head-of-line blocking is intended).
- Credit return: each set bit of crdt_rtn_bank increments that bank's counter by 1. Up to four banks may return credits in the same cycle.
- Same-bank return and consume in the same cycle: the counter is unchanged.
- Return with the counter at CREDITS and no same-cycle consume:
  - counter saturates at CREDITS;
  - crdt_err is set and stays set until reset.
- Counters never go below 0, since a consume requires count != 0.
- Simultaneous push and pop:
  - Allowed when not full: count unchanged, pointers both advance.
  - When empty, the pushed entry becomes the head at the next edge; there is no bypass.
- Pointers are log2(DEPTH) bits and wrap naturally.
- crdt_avail[b] = (crdt_cnt[b] != 0), combinational from the registers.

Decomposition:
- Shared package (cache_pkg), holds:
  - op encoding constants OP_READ/OP_WRITE/OP_FLUSH/OP_INV;
  - typedef chn_req_t {op[1:0], addr[31:4], data[127:0]};
  - the bank-select bit positions (9:8).
- Sub-module sync_fifo (parameterised WIDTH and DEPTH; provides push/pop/full/empty/count). The FIFO is instantiated with chn_req_t.
- Credit counters and issue gating stay in the top module.

Test Plan:
- Reset, then push one read to addr 0x0000_0200 (bank 2) -> valid goes high 1 cycle later; with enable=1 it pops, crdt_cnt[2] goes 4->3 and crdt_avail stays 4'b1111.
- With enable=1, issue 4 reads to bank 1 with no returns, then push a 5th read to bank 1 followed by a write to bank 0 -> 5th read is held with valid=0 and the write is blocked behind it. Pulse crdt_rtn_bank=4'b0010 -> valid rises the next cycle; read and then write issue in order.
- Hold enable=0 with 3 entries queued for 10 cycles -> valid stays high with payload constant; fifo_count=3.
- Push 4 with enable=0 -> up_ready=0 at fifo_count=4. Then enable=1 with up_valid held -> one pop per cycle; up_ready returns 1 the cycle after the first pop.
- At crdt_cnt[3]=3, in the same cycle issue a bank-3 read and assert crdt_rtn_bank[3] -> count remains 3. Then return 1 credit at count 4 -> count stays 4 and crdt_err=1 sticky until reset.
- Assert rstn=0 for one cycle with 2 queued entries and crdt_cnt[0]=1 -> fifo_count=0, valid=0, all counters 4, crdt_err=0.
